// File: rtl/multi_clk_div_if.sv
// Control and status bundle for the multi-channel clock divider.
// The master drives enables and divisor writes; the slave returns divided clocks, ticks and pending flags.
interface multi_clk_div_if #(
  parameter int CH    = 4,
  parameter int CH_W  = 2,
  parameter int CNT_W = 26
);
  logic [CH-1:0]    en;
  logic             sync_clr;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CH-1:0]    clk_out;
  logic [CH-1:0]    tick;
  logic [CH-1:0]    cfg_pending;

  modport master (
    output en, sync_clr, cfg_we, cfg_ch, cfg_div,
    input  clk_out, tick, cfg_pending
  );

  modport slave (
    input  en, sync_clr, cfg_we, cfg_ch, cfg_div,
    output clk_out, tick, cfg_pending
  );
endinterface

// File: rtl/multi_clk_div.sv
// N-channel 50%-duty clock divider with a tick strobe per toggle.
// Each divisor write is shadowed and applied only at a wrap or a sync_clr, so clk_out never glitches.
module multi_clk_div #(
  parameter int               CH      = 4,
  parameter int               CH_W    = 2,
  parameter int               CNT_W   = 26,
  parameter logic [CNT_W-1:0] DEF_DIV = 26'd50000000
) (
  input logic             clk_100M,
  input logic             rst_n,
  multi_clk_div_if.slave  bus
);

  logic [CNT_W-1:0] cnt     [CH];
  logic [CNT_W-1:0] div_act [CH];
  logic [CNT_W-1:0] div_shd [CH];
  logic [CH-1:0]    pending;
  logic [CH-1:0]    clk_q;
  logic [CH-1:0]    tick_q;

  logic [CH-1:0]    wr_sel;
  logic [CH-1:0]    wrap;
  logic [CNT_W-1:0] div_w;

  // A zero divisor would never wrap; it is stored as 1 (toggle every cycle).
  always_comb begin
    div_w  = (bus.cfg_div == '0) ? CNT_W'(1) : bus.cfg_div;
    wr_sel = '0;
    wrap   = '0;
    for (int i = 0; i < CH; i++) begin
      wr_sel[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
      wrap[i]   = bus.en[i] && (cnt[i] == div_act[i] - CNT_W'(1));
    end
  end

  // NOTE: the per-channel arrays are ordinary flops, not RAM, so they take the async reset like any other state.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        cnt[i]     <= '0;
        div_act[i] <= DEF_DIV;
        div_shd[i] <= DEF_DIV;
      end
      pending <= '0;
      clk_q   <= '0;
      tick_q  <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (bus.sync_clr) begin
          cnt[i]    <= '0;
          clk_q[i]  <= 1'b0;
          tick_q[i] <= 1'b0;
          if (pending[i]) div_act[i] <= div_shd[i];
          pending[i] <= 1'b0;
        end else if (wrap[i]) begin
          cnt[i]    <= '0;
          clk_q[i]  <= ~clk_q[i];
          tick_q[i] <= 1'b1;
          if (pending[i]) div_act[i] <= div_shd[i];
          pending[i] <= 1'b0;
        end else begin
          if (bus.en[i]) cnt[i] <= cnt[i] + CNT_W'(1);
          tick_q[i] <= 1'b0;
        end
        // NOTE: this later non-blocking write wins, so a write landing on a wrap stays pending for the next one.
        if (wr_sel[i]) begin
          div_shd[i] <= div_w;
          pending[i] <= 1'b1;
        end
      end
    end
  end

  assign bus.clk_out     = clk_q;
  assign bus.tick        = tick_q;
  assign bus.cfg_pending = pending;

endmodule
